systolic_ctrl: RTL and testbench
================================

# systolic_ctrl

Sequencing controller for the N×N systolic matrix-multiply datapath. It accepts a start request, enables the m0/m1 BRAM read generators, and issues the row-advance pulses and PE-init pulses the array needs. It also generates per-lane result write strobes and addresses into the m2 result memory. When every lane has written its share of the M×M result, it reports completion with a one-cycle done pulse. It sits between the job-level host logic and the mem_read_m0/mem_read_m1/systolic/m2-writeback blocks, replacing the ad hoc sequencing glue currently around them.

## Interface
- D_W, 8, data width (passed through for consistency; not used arithmetically)
- N, 5, array dimension / number of lanes
- M, 5, matrix dimension; M must be a multiple of N
- Derived: WORDS = M*M/N results per lane; AW = max(1, $clog2(WORDS)); CW = $clog2(M)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- column_m0  in  CW  current m0 column index from the array
- valid_m2  in  N  per-lane result-valid from the array
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse
- rd_en  out  1  read enable to both mem_read blocks
- enable_row_count_m0  out  1  one-cycle row-advance pulse to the array
- init_pe  out  1  one-cycle PE-init pulse, feeding the skew pipes
- wr_en  out  N  per-lane m2 write strobe
- wr_addr  out  N*AW  per-lane write offset; lane x occupies bits [x*AW +: AW]; base address x*WORDS is added by the consumer
- overflow  out  1  sticky error flag: a valid arrived on a lane that was already full

## Operation
- State machine with three states: IDLE, RUN, DONE.
  - IDLE: all strobes are 0. start=1 clears the lane counters, the patch counter and overflow, then moves to RUN.
  - RUN: rd_en=1. Moves to DONE in the cycle after every lane count equals WORDS.
  - DONE: done=1 and rd_en=0 for exactly one cycle, then returns to IDLE.
- start is ignored in RUN and DONE; it is not queued.
- Patch counter:
  - Range 1..M/N; reset value 1.
  - In RUN, when column_m0==M-2 and enable_row_count_m0 is currently 0:
    - If patch==M/N: pulse enable_row_count_m0 next cycle and reset patch to 1.
    - Otherwise: increment patch.
  - When enable_row_count_m0 is 1, it clears the next cycle unconditionally.
  - For M/N==1, every qualifying M-2 column pulses.
- init_pe: registered. It is 1 in the cycle after a RUN cycle where column_m0==M-1, otherwise 0.
- Writeback, per lane x:
  - Each lane has a count in 0..WORDS (AW+1 bits).
  - In RUN, valid_m2[x]=1 with count<WORDS: wr_en[x]=1 combinationally, wr_addr[x]=count, and count increments.
  - valid_m2[x]=1 with count==WORDS: wr_en[x]=0, count holds, overflow is set.
  - valid_m2 is ignored outside RUN.
- All column_m0 comparisons are evaluated only in RUN; outside RUN, column_m0 is don't-care.

## Timing
- Reset values: busy=0, done=0, rd_en=0, enable_row_count_m0=0, init_pe=0, wr_en=0, wr_addr=0, overflow=0. State is IDLE, lane counts 0, patch=1.
- rst mid-job has priority over everything. The next cycle is IDLE with reset values; partial counts are discarded.
- Start latency: start sampled high in IDLE at cycle t gives busy=1 and rd_en=1 at t+1.
- wr_en/wr_addr follow valid_m2 combinationally in the same cycle. count updates at the next edge.
- Completion: the final valid is accepted on the last lane at cycle k. Then done=1 and rd_en=0 at k+1, and busy=0 at k+2. A new start is accepted at k+2 at the earliest.
- Simultaneous events:
  - Multiple lanes finishing in the same cycle is legal.
  - start asserted in the DONE cycle is ignored.
  - The column_m0==M-1 and M-2 checks are independent; init_pe and enable_row_count_m0 may both be high in one cycle.

## Test plan
- Reset/idle, M=N=5: hold rst for 3 cycles, then idle for 10 cycles with start=0 -> every output stays 0.
- Full job, M=N=5: start pulse, then column_m0 sweeps 0..4 repeatedly, then 5 valids on each lane with lane x skewed by x cycles:
  - rd_en rises 1 cycle after start.
  - Each lane addresses 0..4 in order.
  - done pulses exactly once, 1 cycle after lane 4's 5th valid.
  - busy falls 1 cycle after done.
- Patch counting, M=10, N=5: column_m0 sweeps 0..9 four times -> enable_row_count_m0 pulses only after the 2nd and 4th occurrence of column 8. init_pe pulses 4 times, each the cycle after column 9.
- Overflow, M=N=5: drive a 6th valid on lane 2 before the other lanes finish -> wr_en[2]=0, wr_addr[2] stays 5 mod range (count holds at 5), overflow=1 until the next start. done timing is unaffected.
- Reset mid-job: assert rst after lane 0 has written 3 words -> next cycle is IDLE with counts 0. A new start followed by 5 valids per lane produces addresses starting at 0.
- start while busy: pulse start again in RUN and in the DONE cycle -> no state change and no second done pulse.

Source files
------------

// File: rtl/systolic_ctrl.sv
// Sequencing controller for the NxN systolic matmul: job FSM, m0 row-advance and
// PE-init pulses, and per-lane m2 writeback strobes/offsets with completion pulse.
module systolic_ctrl #(
  parameter int unsigned D_W = 8,
  parameter int unsigned N   = 5,
  parameter int unsigned M   = 5,
  localparam int unsigned WORDS = M * M / N,
  localparam int unsigned AW    = (WORDS <= 2) ? 1 : $clog2(WORDS),
  localparam int unsigned CW    = $clog2(M)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CW-1:0]   column_m0,
  input  logic [N-1:0]    valid_m2,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic            enable_row_count_m0,
  output logic            init_pe,
  output logic [N-1:0]    wr_en,
  output logic [N*AW-1:0] wr_addr,
  output logic            overflow
);

  localparam int unsigned P  = M / N;
  localparam int unsigned PW = (P < 2) ? 1 : $clog2(P + 1);

  localparam logic [AW:0]   FULL     = (AW+1)'(WORDS);
  localparam logic [CW-1:0] COL_ROW  = CW'(M - 2);
  localparam logic [CW-1:0] COL_LAST = CW'(M - 1);
  localparam logic [PW-1:0] P_MAX    = PW'(P);
  localparam logic [PW-1:0] P_ONE    = PW'(1);

  if ((M % N) != 0 || D_W == 0) begin : g_bad_params
    $error("systolic_ctrl: M must be a non-zero multiple of N and D_W non-zero");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t        state;
  logic [AW:0]   count     [N];
  logic [AW:0]   count_nxt [N];
  logic [PW-1:0] patch;
  logic [N-1:0]  accept;
  logic          ovf_hit;
  logic          all_full_nxt;
  logic          in_run;

  assign in_run = (state == ST_RUN);

  // Per-lane accept/overflow decode and the post-edge "all lanes full" look-ahead.
  always_comb begin
    accept       = '0;
    wr_addr      = '0;
    ovf_hit      = 1'b0;
    all_full_nxt = 1'b1;
    for (int x = 0; x < N; x++) begin
      count_nxt[x] = count[x];
      accept[x]    = in_run && valid_m2[x] && (count[x] != FULL);
      if (in_run && valid_m2[x] && (count[x] == FULL)) begin
        ovf_hit = 1'b1;
      end
      wr_addr[x*AW +: AW] = count[x][AW-1:0];
      count_nxt[x] = count[x] + (AW+1)'(accept[x]);
      if (count_nxt[x] != FULL) begin
        all_full_nxt = 1'b0;
      end
    end
  end

  assign wr_en = accept;

  // Job FSM with registered strobes; the row-advance pulse self-clears after one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      busy                <= 1'b0;
      done                <= 1'b0;
      rd_en               <= 1'b0;
      enable_row_count_m0 <= 1'b0;
      init_pe             <= 1'b0;
      overflow            <= 1'b0;
      patch               <= P_ONE;
      count               <= '{default: '0};
    end else begin
      done                <= 1'b0;
      enable_row_count_m0 <= 1'b0;
      init_pe             <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            rd_en    <= 1'b1;
            overflow <= 1'b0;
            patch    <= P_ONE;
            count    <= '{default: '0};
          end
        end
        ST_RUN: begin
          count   <= count_nxt;
          init_pe <= (column_m0 == COL_LAST);
          if (ovf_hit) begin
            overflow <= 1'b1;
          end
          if ((column_m0 == COL_ROW) && !enable_row_count_m0) begin
            if (patch == P_MAX) begin
              enable_row_count_m0 <= 1'b1;
              patch               <= P_ONE;
            end else begin
              patch <= patch + P_ONE;
            end
          end
          if (all_full_nxt) begin
            state <= ST_DONE;
            done  <= 1'b1;
            rd_en <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          rd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: an M=N=5 instance for jobs/writeback/overflow
// and an M=10,N=5 instance for patch counting.
module tb_systolic_ctrl;

  localparam int unsigned N    = 5;
  localparam int unsigned M5   = 5;
  localparam int unsigned M10  = 10;
  localparam int unsigned W5   = M5 * M5 / N;
  localparam int unsigned AW5  = 3;
  localparam int unsigned AW10 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             start5, start10;
  logic [2:0]       col5;
  logic [3:0]       col10;
  logic [N-1:0]     vld5, vld10;
  logic             busy5, done5, rd5, erc5, init5, ovf5;
  logic             busy10, done10, rd10, erc10, init10, ovf10;
  logic [N-1:0]     wr_en5, wr_en10;
  logic [N*AW5-1:0] wr_addr5;
  logic [N*AW10-1:0] wr_addr10;

  systolic_ctrl #(.D_W(8), .N(N), .M(M5)) u5 (
    .clk(clk), .rst(rst), .start(start5), .column_m0(col5), .valid_m2(vld5),
    .busy(busy5), .done(done5), .rd_en(rd5), .enable_row_count_m0(erc5),
    .init_pe(init5), .wr_en(wr_en5), .wr_addr(wr_addr5), .overflow(ovf5)
  );

  systolic_ctrl #(.D_W(8), .N(N), .M(M10)) u10 (
    .clk(clk), .rst(rst), .start(start10), .column_m0(col10), .valid_m2(vld10),
    .busy(busy10), .done(done10), .rd_en(rd10), .enable_row_count_m0(erc10),
    .init_pe(init10), .wr_en(wr_en10), .wr_addr(wr_addr10), .overflow(ovf10)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: job phase, accepted words per lane, expected event cycles.
  typedef enum int {P_IDLE, P_RUN, P_DONE} ph_t;
  ph_t cur_ph = P_IDLE, nxt_ph;
  int  acc [N];
  int  wr_q [N][$];
  int  ev_q [5][$];   // 0 done5, 1 erc5, 2 init5, 3 erc10, 4 init10
  bit  cur_ovf, nxt_ovf, cur_erc5, nxt_erc5, cur_erc10, nxt_erc10;
  bit  run10, nxt_run10;
  int  occ5, occ10;
  bit  mon_en = 1'b0;
  int  n_done = 0, cnt_erc10 = 0, cnt_init10 = 0;
  int  ovf_chk_cyc = -1;

  task automatic model_reset();
    cur_ph = P_IDLE; cur_ovf = 1'b0; cur_erc5 = 1'b0; run10 = 1'b0; cur_erc10 = 1'b0;
    for (int x = 0; x < N; x++) begin acc[x] = 0; wr_q[x].delete(); end
    for (int e = 0; e < 5; e++) ev_q[e].delete();
  endtask

  // Drive one cycle of inputs, predict the responses, advance to the next cycle.
  task automatic step(input bit st5, input logic [2:0] c5, input logic [N-1:0] v5,
                      input bit st10, input logic [3:0] c10);
    bit all_full;
    start5 = st5; col5 = c5; vld5 = v5; start10 = st10; col10 = c10;
    nxt_ph = cur_ph; nxt_ovf = cur_ovf; nxt_erc5 = 1'b0;
    case (cur_ph)
      P_IDLE: if (st5) begin
        nxt_ph = P_RUN; nxt_ovf = 1'b0; occ5 = 0;
        for (int x = 0; x < N; x++) acc[x] = 0;
      end
      P_RUN: begin
        all_full = 1'b1;
        for (int x = 0; x < N; x++) begin
          if (v5[x]) begin
            if (acc[x] < W5) begin wr_q[x].push_back(acc[x]); acc[x]++; end
            else nxt_ovf = 1'b1;
          end
          if (acc[x] != W5) all_full = 1'b0;
        end
        if (c5 == 3'(M5 - 1)) ev_q[2].push_back(cyc + 1);
        if (c5 == 3'(M5 - 2) && !cur_erc5) begin
          occ5++;
          if (occ5 % (M5 / N) == 0) begin ev_q[1].push_back(cyc + 1); nxt_erc5 = 1'b1; end
        end
        if (all_full) begin nxt_ph = P_DONE; ev_q[0].push_back(cyc + 1); end
      end
      default: nxt_ph = P_IDLE;
    endcase
    nxt_run10 = run10; nxt_erc10 = 1'b0;
    if (!run10) begin
      if (st10) begin nxt_run10 = 1'b1; occ10 = 0; end
    end else begin
      if (c10 == 4'(M10 - 1)) ev_q[4].push_back(cyc + 1);
      if (c10 == 4'(M10 - 2) && !cur_erc10) begin
        occ10++;
        if (occ10 % (M10 / N) == 0) begin ev_q[3].push_back(cyc + 1); nxt_erc10 = 1'b1; end
      end
    end
    @(posedge clk); #1;
    cur_ph = nxt_ph; cur_ovf = nxt_ovf; cur_erc5 = nxt_erc5;
    run10 = nxt_run10; cur_erc10 = nxt_erc10;
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1; start5 = 0; start10 = 0; col5 = 0; col10 = 0; vld5 = 0;
    @(posedge clk); #1;
    model_reset();
    mon_en = 1'b1;
    repeat (n - 1) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  // Monitor: compares every DUT output against the scoreboard once per cycle.
  string ev_name [5] = '{"done5", "erc5", "init5", "erc10", "init10"};
  always @(negedge clk) begin
    if (mon_en) begin
      logic [4:0] ev_act;
      bit exp;
      ev_act = {init10, erc10, init5, erc5, done5};
      chk("busy5", busy5, cur_ph != P_IDLE);
      chk("rd_en5", rd5, cur_ph == P_RUN);
      chk("overflow5", ovf5, cur_ovf);
      chk("busy10", busy10, run10);
      chk("rd_en10", rd10, run10);
      chk("done10", done10, 0);
      chk("wr_en10", wr_en10, 0);
      for (int x = 0; x < N; x++) begin
        if (wr_en5[x]) begin
          if (wr_q[x].size() == 0) chk($sformatf("unexpected_wr_lane%0d", x), 1, 0);
          else chk($sformatf("wr_addr_lane%0d", x), wr_addr5[x*AW5 +: AW5], wr_q[x].pop_front());
        end else if (wr_q[x].size() > 0) begin
          chk($sformatf("missing_wr_lane%0d", x), 0, 1);
          void'(wr_q[x].pop_front());
        end
      end
      for (int e = 0; e < 5; e++) begin
        exp = (ev_q[e].size() > 0) && (ev_q[e][0] == cyc);
        chk(ev_name[e], ev_act[e], exp);
        if (exp) void'(ev_q[e].pop_front());
      end
      if (cyc == ovf_chk_cyc) begin
        chk("ovf_lane2_wr_en", wr_en5[2], 0);
        chk("ovf_lane2_addr", wr_addr5[2*AW5 +: AW5], W5);
      end
      if (done5) n_done++;
      if (erc10) cnt_erc10++;
      if (init10) cnt_init10++;
    end
  end

  // One job on the M=5 instance; start is re-pulsed mid-RUN and in the DONE cycle.
  task automatic run_job(input int ovf_lane, input bit skew, input bit gaps, input bit rand_col);
    int sent [N];
    int tgt [N];
    int off [N];
    int t, nd0;
    logic [N-1:0] v;
    logic [2:0] c;
    nd0 = n_done;
    step(1'b1, 3'd0, '0, 1'b0, 4'd0);
    for (int x = 0; x < N; x++) begin
      sent[x] = 0;
      tgt[x]  = W5 + ((x == ovf_lane) ? 1 : 0);
      off[x]  = skew ? x : 0;
      if (ovf_lane >= 0 && x != ovf_lane) off[x] = 8;
    end
    t = 0;
    while (cur_ph != P_IDLE && t < 300) begin
      v = '0;
      for (int x = 0; x < N; x++) begin
        if (sent[x] < tgt[x] && t >= off[x] && (!gaps || $urandom_range(0, 2) != 0)) begin
          v[x] = 1'b1;
          sent[x]++;
          if (sent[x] == W5 + 1) ovf_chk_cyc = cyc;
        end
      end
      c = rand_col ? 3'($urandom_range(0, M5 - 1)) : 3'(t % M5);
      step((t == 3) || (cur_ph == P_DONE), c, v, 1'b0, 4'd0);
      t++;
    end
    chk("job_timeout", int'(t < 300), 1);
    step(1'b0, 3'd0, '0, 1'b0, 4'd0);
    step(1'b0, 3'd0, '0, 1'b0, 4'd0);
    chk("done_pulses_per_job", n_done - nd0, 1);
  endtask

  initial begin
    rst = 1'b1; start5 = 0; start10 = 0; col5 = 0; col10 = 0; vld5 = 0; vld10 = 0;
    model_reset();

    reset_cycles(3);
    repeat (10) begin
      step(1'b0, 3'd0, '0, 1'b0, 4'd0);
      chk("idle_wr_addr5", wr_addr5, 0);
      chk("idle_wr_addr10", wr_addr10, 0);
    end

    run_job(-1, 1'b1, 1'b0, 1'b0);

    step(1'b0, 3'd0, '0, 1'b1, 4'd0);
    for (int i = 0; i < 4 * M10; i++) step(1'b0, 3'd0, '0, 1'b0, 4'(i % M10));
    repeat (3) step(1'b0, 3'd0, '0, 1'b0, 4'd0);
    chk("erc10_pulse_count", cnt_erc10, 2);
    chk("init10_pulse_count", cnt_init10, 4);

    run_job(2, 1'b0, 1'b0, 1'b0);
    chk("overflow_sticky_after_done", ovf5, 1);

    step(1'b1, 3'd0, '0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 3'(i), 5'b00001, 1'b0, 4'd0);
    reset_cycles(1);
    chk("midjob_reset_busy", busy5, 0);
    chk("midjob_reset_wr_addr", wr_addr5, 0);
    step(1'b0, 3'd0, '0, 1'b0, 4'd0);
    run_job(-1, 1'b0, 1'b1, 1'b0);

    for (int j = 0; j < 4; j++) run_job(-1, j[0], 1'b1, 1'b1);

    repeat (4) step(1'b0, 3'd0, '0, 1'b0, 4'd0);
    for (int x = 0; x < N; x++) chk("wr_queue_drained", wr_q[x].size(), 0);
    for (int e = 0; e < 5; e++) chk("event_queue_drained", ev_q[e].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
